// File: rtl/pixel_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_array_ctrl
//  Description : Frame sequencer for the pixel array. Runs
//                ERASE -> EXPOSE -> CONVERT -> READOUT once per frame, drives
//                the shared DATA bus with a ramp during CONVERT and streams
//                every pixel value to a sink over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_array_ctrl #(
    parameter int ROW_NUM        = 2,
    parameter int COLUMN_NUM     = 2,
    parameter int ADDR_BITS      = 2,
    parameter int ERASE_CYCLES   = 5,
    parameter int EXPOSE_CYCLES  = 255,
    parameter int CONVERT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 ERASE,
    output logic                 EXPOSE,
    output logic                 CONVERT,
    output logic                 READ,
    output logic [ADDR_BITS-1:0] PIXELADDR,
    inout  wire  [7:0]           DATA,
    output logic [7:0]           pix_data,
    output logic [ADDR_BITS-1:0] pix_addr,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 busy,
    output logic                 frame_done
);

    // State encoding
    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_ERASE   = 3'd1;
    localparam logic [2:0] c_S_EXPOSE  = 3'd2;
    localparam logic [2:0] c_S_CONVERT = 3'd3;
    localparam logic [2:0] c_S_READOUT = 3'd4;
    localparam logic [2:0] c_S_DONE    = 3'd5;

    // Last counter value of each timed state; 9 bits so a length of 256 is reachable
    localparam logic [8:0] c_ERASE_LAST   = 9'(ERASE_CYCLES - 1);
    localparam logic [8:0] c_EXPOSE_LAST  = 9'(EXPOSE_CYCLES - 1);
    localparam logic [8:0] c_CONVERT_LAST = 9'(CONVERT_CYCLES - 1);

    // Per-pixel readout phases, carried in the shared cycle counter
    localparam logic [8:0] c_PH_SETTLE  = 9'd0;
    localparam logic [8:0] c_PH_CAPTURE = 9'd1;
    localparam logic [8:0] c_PH_HOLD    = 9'd2;

    localparam logic [ADDR_BITS-1:0] c_LAST_ADDR = ADDR_BITS'(ROW_NUM * COLUMN_NUM - 1);
    localparam logic [ADDR_BITS-1:0] c_ADDR_ONE  = ADDR_BITS'(1);

    logic [2:0]           state_q,     state_d;
    logic [8:0]           cnt_q,       cnt_d;
    logic [ADDR_BITS-1:0] addr_q,      addr_d;
    logic [7:0]           pix_data_q,  pix_data_d;
    logic [ADDR_BITS-1:0] pix_addr_q,  pix_addr_d;
    logic                 pix_valid_q, pix_valid_d;

    // State register and datapath registers; reset aborts any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= c_S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            pix_data_q  <= '0;
            pix_addr_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            pix_data_q  <= pix_data_d;
            pix_addr_q  <= pix_addr_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    // Next-state logic: counter is cleared on every state entry
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        pix_data_d  = pix_data_q;
        pix_addr_d  = pix_addr_q;
        pix_valid_d = pix_valid_q;
        case (state_q)
            c_S_IDLE: begin
                if (start) begin
                    state_d = c_S_ERASE;
                    cnt_d   = '0;
                end
            end
            c_S_ERASE: begin
                if (cnt_q == c_ERASE_LAST) begin
                    state_d = c_S_EXPOSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            c_S_EXPOSE: begin
                if (cnt_q == c_EXPOSE_LAST) begin
                    state_d = c_S_CONVERT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            c_S_CONVERT: begin
                if (cnt_q == c_CONVERT_LAST) begin
                    state_d = c_S_READOUT;
                    cnt_d   = c_PH_SETTLE;
                    addr_d  = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            c_S_READOUT: begin
                if (cnt_q == c_PH_SETTLE) begin
                    // Give the array one cycle to settle on the new address
                    cnt_d = c_PH_CAPTURE;
                end else if (cnt_q == c_PH_CAPTURE) begin
                    pix_data_d  = DATA;
                    pix_addr_d  = addr_q;
                    pix_valid_d = 1'b1;
                    cnt_d       = c_PH_HOLD;
                end else if (pix_ready) begin
                    // Handshake: release the beat and move to the next pixel
                    pix_valid_d = 1'b0;
                    cnt_d       = c_PH_SETTLE;
                    if (addr_q == c_LAST_ADDR) begin
                        state_d = c_S_DONE;
                    end else begin
                        addr_d = addr_q + c_ADDR_ONE;
                    end
                end
            end
            c_S_DONE: begin
                state_d = c_S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = c_S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: strobes are pure functions of the current state
    always_comb begin
        ERASE      = 1'b0;
        EXPOSE     = 1'b0;
        CONVERT    = 1'b0;
        READ       = 1'b0;
        frame_done = 1'b0;
        busy       = (state_q != c_S_IDLE);
        case (state_q)
            c_S_ERASE:   ERASE      = 1'b1;
            c_S_EXPOSE:  EXPOSE     = 1'b1;
            c_S_CONVERT: CONVERT    = 1'b1;
            c_S_READOUT: READ       = 1'b1;
            c_S_DONE:    frame_done = 1'b1;
            default:     ;
        endcase
    end

    // Ramp is driven only while converting; the bus is released on the same edge
    // that enters READOUT, so controller and array never drive together
    assign DATA = CONVERT ? cnt_q[7:0] : 8'bz;

    assign PIXELADDR = addr_q;
    assign pix_data  = pix_data_q;
    assign pix_addr  = pix_addr_q;
    assign pix_valid = pix_valid_q;

endmodule
`default_nettype wire
